cycle_count_gen: RTL and testbench
==================================

// Module: cycle_count_gen
// PURPOSE
//  Upstream producer of the cycle_count bus watched by the passive DPI collector bound into hello_world.
//  Run/stop FSM with prescaler and optional terminal count.
//  Registered count plus a one-cycle change strobe, so the collector fires c_monitor once per change.
//  Optional snapshot channel hands a captured count to a consumer via valid/ready.
// PARAMETERS
//  WIDTH      32  count width in bits; cycle_count wraps modulo 2^WIDTH
//  PRESCALE   1   clk cycles per increment while RUN; legal range 1..65535
//  MAX_COUNT  0   0 = free-run with wrap; else terminal value, legal range 1..2^WIDTH-1
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      level; IDLE->RUN request
//  stop         in   1      level; RUN->IDLE request
//  clear        in   1      level; zero count and prescaler
//  cycle_count  out  WIDTH  registered count
//  count_chg    out  1      1-cycle pulse, same cycle cycle_count takes a new value
//  wrap         out  1      1-cycle pulse, same cycle cycle_count wraps 2^WIDTH-1 -> 0
//  done         out  1      high while FSM is DONE
//  snap_req     in   1      capture request
//  snap_valid   out  1      snapshot available
//  snap_ready   in   1      consumer accepts snapshot
//  snap_data    out  WIDTH  captured count
//  snap_ovr     out  1      sticky; a request was dropped
// BEHAVIOUR
//  Reset, sampled only at posedge clk with rst_n=0:
//   - all outputs 0, state IDLE, prescaler 0.
//   - Mid-operation reset discards any pending snapshot.
//  FSM states and transitions:
//   - IDLE: start -> RUN; stop ignored.
//   - RUN: stop -> IDLE; the count is held and the prescaler is zeroed.
//   - DONE: start and stop ignored; clear -> IDLE.
//  Input priority: clear > stop > start.
//  Increment:
//   - In RUN, pre increments every cycle.
//   - When pre==PRESCALE-1: pre<=0 and cycle_count<=cycle_count+1, with count_chg=1 in that same cycle.
//   - Latency from start high to the first count_chg is PRESCALE+1 cycles.
//   - PRESCALE=1 gives one increment per cycle.
//  Terminal count (MAX_COUNT!=0): the increment that reaches MAX_COUNT loads MAX_COUNT and moves the FSM to DONE.
//   - done=1 from the cycle the count equals MAX_COUNT; no further increments.
//  Wrap (MAX_COUNT=0): 2^WIDTH-1 -> 0 gives count_chg=1 and wrap=1; the FSM stays in RUN.
//  clear, in any state:
//   - cycle_count<=0 and pre<=0 next cycle.
//   - count_chg=1 only if the old value was nonzero.
//   - RUN stays RUN; DONE -> IDLE; IDLE stays IDLE.
//   - clear concurrent with an increment: clear wins and the count becomes 0.
//  count_chg never asserts without an actual value change.
// CONFIGURATION
//  CYCLE_COUNT_GEN_SNAPSHOT_EN defined (snapshot channel present):
//   - snap_req with !snap_valid: snap_data<=cycle_count (pre-update value); snap_valid=1 next cycle.
//   - snap_valid held until snap_valid&&snap_ready; snap_data stable while valid.
//   - snap_req with valid&&ready in the same cycle: new capture, snap_valid stays 1.
//   - snap_req with valid&&!ready: request dropped and snap_ovr<=1; cleared only by reset.
//  CYCLE_COUNT_GEN_SNAPSHOT_EN undefined:
//   - no capture logic; snap_valid, snap_data and snap_ovr tied 0.
//   - snap_req and snap_ready are ignored.
// TESTING
//  T1 reset, PRESCALE=1, start held 1 cycle:
//   - first count_chg 2 cycles later with cycle_count=1.
//   - count=5 after 6 cycles.
//  T2 PRESCALE=3, run 10 cycles:
//   - count=3 at that point.
//   - count_chg pulses exactly 3 times, 3 cycles apart.
//  T3 MAX_COUNT=4, PRESCALE=1:
//   - count stops at 4 with done=1; start ignored.
//   - clear -> count=0, done=0, IDLE.
//  T4 WIDTH=4, MAX_COUNT=0:
//   - count 15 -> 0 with wrap=1 and count_chg=1 in the same cycle.
//   - the FSM stays in RUN.
//  T5 clear+stop+increment in the same cycle at count=7:
//   - count=0 with count_chg=1.
//   - state becomes IDLE (stop applies after clear).
//  T6 SNAPSHOT_EN, snap_req at count=9 with snap_ready=0:
//   - snap_valid=1 and snap_data=9.
//   - a second snap_req sets snap_ovr=1 and snap_data stays 9.
//   - snap_ready=1 -> snap_valid=0 next cycle.

Source files
------------

// File: rtl/cycle_count_gen.sv
// rtl/cycle_count_gen.sv - run/stop cycle counter with prescaler, terminal count and optional snapshot channel (macro CYCLE_COUNT_GEN_SNAPSHOT_EN)
module cycle_count_gen #(
  parameter int unsigned        WIDTH     = 32,
  parameter int unsigned        PRESCALE  = 1,
  parameter logic [WIDTH-1:0]   MAX_COUNT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] cycle_count,
  output logic             count_chg,
  output logic             wrap,
  output logic             done,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_ovr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0]      PRE_LAST     = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_ALL_ONES = '1;
  localparam bit               TERMINAL_EN  = (MAX_COUNT != '0);

  logic [1:0]       state_q, state_d;
  logic [15:0]      pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             inc;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = cnt_q + WIDTH'(1);

  // Next-state: FSM transitions, prescaler tick, increment, then clear overriding everything on the count
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    wrap_d  = 1'b0;
    inc     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          inc   = 1'b1;
        end else begin
          pre_d = pre_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (inc) begin
      cnt_d = cnt_inc;
      chg_d = 1'b1;
      if (TERMINAL_EN && (cnt_inc == MAX_COUNT)) begin
        state_d = ST_DONE;
      end
      if (!TERMINAL_EN && (cnt_q == CNT_ALL_ONES)) begin
        wrap_d = 1'b1;
      end
    end

    // clear still lets stop/start steer the FSM, but a terminal hit it cancelled must not reach DONE
    if (clear) begin
      cnt_d  = '0;
      pre_d  = '0;
      chg_d  = (cnt_q != '0);
      wrap_d = 1'b0;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end else if (state_d == ST_DONE) begin
        state_d = ST_RUN;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  // Counter state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign cycle_count = cnt_q;
  assign count_chg   = chg_q;
  assign wrap        = wrap_q;
  assign done        = done_q;

`ifdef CYCLE_COUNT_GEN_SNAPSHOT_EN
  logic             snap_valid_q, snap_valid_d;
  logic [WIDTH-1:0] snap_data_q, snap_data_d;
  logic             snap_ovr_q, snap_ovr_d;

  // Snapshot handshake: capture when the slot is free or being drained this cycle, else flag the drop
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    snap_ovr_d   = snap_ovr_q;
    if (snap_valid_q && snap_ready) begin
      snap_valid_d = 1'b0;
    end
    if (snap_req) begin
      if (!snap_valid_q || snap_ready) begin
        snap_valid_d = 1'b1;
        snap_data_d  = cnt_q;
      end else begin
        snap_ovr_d = 1'b1;
      end
    end
  end

  // Snapshot registers; reset drops any pending capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      snap_ovr_q   <= 1'b0;
    end else begin
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
      snap_ovr_q   <= snap_ovr_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign snap_ovr   = snap_ovr_q;
`else
  logic snap_unused;
  assign snap_unused = snap_req ^ snap_ready;
  assign snap_valid  = 1'b0;
  assign snap_data   = '0;
  assign snap_ovr    = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_count_gen.sv
// tb/tb_cycle_count_gen.sv - scoreboard bench for cycle_count_gen across four parameterisations
module tb_cycle_count_gen;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic        wrp;
    logic        dn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v, stop_v, clear_v;
  logic        snap_req, snap_ready;

  logic [31:0] cnt_w [4];
  logic [31:0] sd_w  [4];
  logic [3:0]  chg_w, wrp_w, dn_w, sv_w, so_w;
  logic [3:0]  cnt4, sd4;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n0;
  exp_t        exp_q [4][$];

  always #5 clk = ~clk;

  // Cycle stamp used to check when each count_chg appears
  always @(posedge clk) cyc <= cyc + 1;

  assign cnt_w[3] = {28'd0, cnt4};
  assign sd_w[3]  = {28'd0, sd4};

  cycle_count_gen #(.WIDTH(32), .PRESCALE(1), .MAX_COUNT(32'd0)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .clear(clear_v[0]),
    .cycle_count(cnt_w[0]), .count_chg(chg_w[0]), .wrap(wrp_w[0]), .done(dn_w[0]),
    .snap_req(snap_req), .snap_valid(sv_w[0]), .snap_ready(snap_ready),
    .snap_data(sd_w[0]), .snap_ovr(so_w[0]));

  cycle_count_gen #(.WIDTH(32), .PRESCALE(3), .MAX_COUNT(32'd0)) u_p3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .clear(clear_v[1]),
    .cycle_count(cnt_w[1]), .count_chg(chg_w[1]), .wrap(wrp_w[1]), .done(dn_w[1]),
    .snap_req(1'b0), .snap_valid(sv_w[1]), .snap_ready(1'b0),
    .snap_data(sd_w[1]), .snap_ovr(so_w[1]));

  cycle_count_gen #(.WIDTH(32), .PRESCALE(1), .MAX_COUNT(32'd4)) u_max (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]), .clear(clear_v[2]),
    .cycle_count(cnt_w[2]), .count_chg(chg_w[2]), .wrap(wrp_w[2]), .done(dn_w[2]),
    .snap_req(1'b0), .snap_valid(sv_w[2]), .snap_ready(1'b0),
    .snap_data(sd_w[2]), .snap_ovr(so_w[2]));

  cycle_count_gen #(.WIDTH(4), .PRESCALE(1), .MAX_COUNT(4'd0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .stop(stop_v[3]), .clear(clear_v[3]),
    .cycle_count(cnt4), .count_chg(chg_w[3]), .wrap(wrp_w[3]), .done(dn_w[3]),
    .snap_req(1'b0), .snap_valid(sv_w[3]), .snap_ready(1'b0),
    .snap_data(sd4), .snap_ovr(so_w[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int c, input logic [31:0] v, input logic w, input logic d);
    exp_t e;
    e.cyc = c;
    e.cnt = v;
    e.wrp = w;
    e.dn  = d;
    exp_q[idx].push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every count_chg pulse must match the next expected change, including its cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (wrp_w[i] && !chg_w[i]) begin
          chk($sformatf("wrap_without_chg[%0d]", i), 32'(wrp_w[i]), 32'd0);
        end
        if (chg_w[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_chg[%0d] cnt=%0d", i, cnt_w[i]), 32'd1, 32'd0);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("chg_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
            chk($sformatf("chg_count[%0d]", i), cnt_w[i], e.cnt);
            chk($sformatf("chg_wrap[%0d]", i), 32'(wrp_w[i]), 32'(e.wrp));
            chk($sformatf("chg_done[%0d]", i), 32'(dn_w[i]), 32'(e.dn));
          end
        end
      end
    end
  end

  // Directed stimulus; expected changes are queued before the stimulus that causes them
  initial begin
    rst_n = 1'b0;
    start_v = '0; stop_v = '0; clear_v = '0;
    snap_req = 1'b0; snap_ready = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_count[%0d]", i), cnt_w[i], 32'd0);
      chk($sformatf("rst_flags[%0d]", i), {28'd0, chg_w[i], wrp_w[i], dn_w[i], so_w[i]}, 32'd0);
      chk($sformatf("rst_snap_valid[%0d]", i), 32'(sv_w[i]), 32'd0);
      chk($sformatf("rst_snap_data[%0d]", i), sd_w[i], 32'd0);
    end
    rst_n = 1'b1;
    step(1);

    // T1: PRESCALE=1, one-cycle start pulse
    n0 = cyc;
    for (int k = 1; k <= 5; k++) push(0, n0 + 1 + k, 32'(k), 1'b0, 1'b0);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(5);
    chk("t1_count_after_6", cnt_w[0], 32'd5);
    stop_v[0] = 1'b1;
    step(1);
    stop_v[0] = 1'b0;
    step(3);
    chk("t1_held_after_stop", cnt_w[0], 32'd5);

    // T5: clear + stop + increment together at count 7
    n0 = cyc;
    push(0, n0 + 2, 32'd6, 1'b0, 1'b0);
    push(0, n0 + 3, 32'd7, 1'b0, 1'b0);
    push(0, n0 + 4, 32'd0, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(2);
    chk("t5_count_before", cnt_w[0], 32'd7);
    clear_v[0] = 1'b1;
    stop_v[0] = 1'b1;
    step(1);
    clear_v[0] = 1'b0;
    stop_v[0] = 1'b0;
    chk("t5_count_cleared", cnt_w[0], 32'd0);
    step(4);
    chk("t5_idle_no_count", cnt_w[0], 32'd0);
    clear_v[0] = 1'b1;
    step(1);
    clear_v[0] = 1'b0;
    step(2);
    chk("clear_at_zero_count", cnt_w[0], 32'd0);

    // T2: PRESCALE=3 for 10 cycles
    n0 = cyc;
    push(1, n0 + 4, 32'd1, 1'b0, 1'b0);
    push(1, n0 + 7, 32'd2, 1'b0, 1'b0);
    push(1, n0 + 10, 32'd3, 1'b0, 1'b0);
    start_v[1] = 1'b1;
    step(1);
    start_v[1] = 1'b0;
    step(9);
    chk("t2_count_after_10", cnt_w[1], 32'd3);
    stop_v[1] = 1'b1;
    step(1);
    stop_v[1] = 1'b0;
    step(4);
    chk("t2_held_after_stop", cnt_w[1], 32'd3);

    // T3: terminal count 4
    n0 = cyc;
    for (int k = 1; k <= 3; k++) push(2, n0 + 1 + k, 32'(k), 1'b0, 1'b0);
    push(2, n0 + 5, 32'd4, 1'b0, 1'b1);
    start_v[2] = 1'b1;
    step(1);
    start_v[2] = 1'b0;
    step(4);
    chk("t3_count_terminal", cnt_w[2], 32'd4);
    chk("t3_done_set", 32'(dn_w[2]), 32'd1);
    start_v[2] = 1'b1;
    step(3);
    start_v[2] = 1'b0;
    chk("t3_start_ignored", cnt_w[2], 32'd4);
    chk("t3_done_held", 32'(dn_w[2]), 32'd1);
    push(2, cyc + 1, 32'd0, 1'b0, 1'b0);
    clear_v[2] = 1'b1;
    step(1);
    clear_v[2] = 1'b0;
    chk("t3_clear_count", cnt_w[2], 32'd0);
    chk("t3_clear_done", 32'(dn_w[2]), 32'd0);
    step(3);
    chk("t3_idle_after_clear", cnt_w[2], 32'd0);

    // T4: WIDTH=4 wrap
    n0 = cyc;
    for (int k = 1; k <= 15; k++) push(3, n0 + 1 + k, 32'(k), 1'b0, 1'b0);
    push(3, n0 + 17, 32'd0, 1'b1, 1'b0);
    push(3, n0 + 18, 32'd1, 1'b0, 1'b0);
    start_v[3] = 1'b1;
    step(1);
    start_v[3] = 1'b0;
    step(16);
    chk("t4_wrapped_count", cnt_w[3], 32'd0);
    chk("t4_wrap_pulse", 32'(wrp_w[3]), 32'd1);
    step(1);
    chk("t4_still_running", cnt_w[3], 32'd1);
    chk("t4_wrap_one_cycle", 32'(wrp_w[3]), 32'd0);
    stop_v[3] = 1'b1;
    step(1);
    stop_v[3] = 1'b0;

`ifdef CYCLE_COUNT_GEN_SNAPSHOT_EN
    // T6: snapshot channel
    n0 = cyc;
    for (int k = 1; k <= 9; k++) push(0, n0 + 1 + k, 32'(k), 1'b0, 1'b0);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(9);
    stop_v[0] = 1'b1;
    step(1);
    stop_v[0] = 1'b0;
    chk("t6_count_9", cnt_w[0], 32'd9);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    chk("t6_valid", 32'(sv_w[0]), 32'd1);
    chk("t6_data", sd_w[0], 32'd9);
    chk("t6_ovr_clear", 32'(so_w[0]), 32'd0);
    push(0, cyc + 1, 32'd0, 1'b0, 1'b0);
    clear_v[0] = 1'b1;
    step(1);
    clear_v[0] = 1'b0;
    chk("t6_data_stable", sd_w[0], 32'd9);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    chk("t6_ovr_set", 32'(so_w[0]), 32'd1);
    chk("t6_data_kept", sd_w[0], 32'd9);
    chk("t6_valid_kept", 32'(sv_w[0]), 32'd1);
    snap_ready = 1'b1;
    step(1);
    snap_ready = 1'b0;
    chk("t6_valid_drained", 32'(sv_w[0]), 32'd0);
    chk("t6_ovr_sticky", 32'(so_w[0]), 32'd1);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    chk("t6_recapture_data", sd_w[0], 32'd0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("t6_reset_drops_valid", 32'(sv_w[0]), 32'd0);
    chk("t6_reset_clears_ovr", 32'(so_w[0]), 32'd0);
`else
    snap_req = 1'b1;
    step(2);
    snap_req = 1'b0;
    chk("snap_off_valid", 32'(sv_w[0]), 32'd0);
    chk("snap_off_ovr", 32'(so_w[0]), 32'd0);
    chk("snap_off_data", sd_w[0], 32'd0);
`endif

    step(5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("missing_chg[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
